// File: rtl/io_peripheral_decoder.sv
// CPU I/O-space address decoder: selects one of NUM_CH peripheral windows,
// inserts wait states, and answers with a registered data acknowledge or bus error.
module io_peripheral_decoder #(
  parameter int              NUM_CH      = 4,
  parameter logic [15:0]     BASE_ADDR   = 16'h8000,
  parameter int              STRIDE      = 4,
  parameter int              WAIT_STATES = 2,
  parameter int              TIMEOUT     = 255
) (
  input  logic              Clock,
  input  logic              Reset_L,
  input  logic [31:0]       Address,
  input  logic              IOSelect_H,
  input  logic              AS_L,
  input  logic [NUM_CH-1:0] Ready_H,
  output logic [NUM_CH-1:0] Enable_H,
  output logic              DtAck_L,
  output logic              BErr_L
);

  localparam int          IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [16:0] TOP_ADDR = 17'(BASE_ADDR) + 17'(NUM_CH << STRIDE);
  localparam logic [8:0]  WS       = 9'(WAIT_STATES);
  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic [15:0]      addr_lo;
  logic [15:0]      offset;
  logic [15:0]      off_sh;
  logic [IDX_W-1:0] addr_idx;
  logic             hit;
  logic             wait_done;
  logic             unused_ok;

  assign addr_lo  = Address[15:0];
  assign offset   = addr_lo - BASE_ADDR;
  assign off_sh   = offset >> STRIDE;
  assign addr_idx = off_sh[IDX_W-1:0];
  // 17-bit compare so a window ending exactly at 64K does not wrap
  assign hit = !AS_L && IOSelect_H &&
               ({1'b0, addr_lo} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, addr_lo} <  TOP_ADDR);
  assign wait_done = ({1'b0, cnt_q} + 9'd1) > WS;
  assign unused_ok = ^{Address[31:16], off_sh};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    en_d    = en_q;
    ack_d   = ack_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        en_d  = '0;
        ack_d = 1'b0;
        err_d = 1'b0;
        if (hit) begin
          idx_d           = addr_idx;
          cnt_d           = 8'd0;
          en_d[addr_idx]  = 1'b1;
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        if (AS_L) begin
          state_d = S_IDLE;
          en_d    = '0;
        end else begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          // acknowledge wins over timeout on the same edge
          if (wait_done && Ready_H[idx_q]) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
          end else if (cnt_q == TO_LAST) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_ACK, S_ERR: begin
        if (AS_L) begin
          state_d = S_IDLE;
          en_d    = '0;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = '0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      en_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign Enable_H = en_q;
  assign DtAck_L  = ~ack_q;
  assign BErr_L   = ~err_q;

endmodule

// File: tb/tb_io_peripheral_decoder.sv
// Directed bench for io_peripheral_decoder: default instance plus an 8-channel,
// zero-wait-state instance.
module tb_io_peripheral_decoder;

  logic        Clock = 1'b0;
  logic        Reset_L;
  logic [31:0] Address;
  logic        IOSelect_H;
  logic        AS_L;
  logic [3:0]  Ready4;
  logic [7:0]  Ready8;
  logic [3:0]  En4;
  logic [7:0]  En8;
  logic        DtAck4, BErr4, DtAck8, BErr8;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  io_peripheral_decoder dut (
    .Clock(Clock), .Reset_L(Reset_L), .Address(Address), .IOSelect_H(IOSelect_H),
    .AS_L(AS_L), .Ready_H(Ready4), .Enable_H(En4), .DtAck_L(DtAck4), .BErr_L(BErr4)
  );

  io_peripheral_decoder #(.NUM_CH(8), .WAIT_STATES(0)) dut8 (
    .Clock(Clock), .Reset_L(Reset_L), .Address(Address), .IOSelect_H(IOSelect_H),
    .AS_L(AS_L), .Ready_H(Ready8), .Enable_H(En8), .DtAck_L(DtAck8), .BErr_L(BErr8)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_L    = 1'b0;
    Address    = 32'h0;
    IOSelect_H = 1'b1;
    AS_L       = 1'b1;
    Ready4     = 4'hF;
    Ready8     = 8'hFF;
    tick();
    tick();
    check("rst_en",    32'(En4),    32'h0);
    check("rst_dtack", 32'(DtAck4), 32'h1);
    check("rst_berr",  32'(BErr4),  32'h1);
    Reset_L = 1'b1;
    tick();

    // Basic access to channel 1, two wait states
    Address = 32'h0040_8010;
    AS_L    = 1'b0;
    tick();
    check("t1_en_e0",    32'(En4),    32'h2);
    check("t1_dtack_e0", 32'(DtAck4), 32'h1);
    tick();
    check("t1_dtack_e1", 32'(DtAck4), 32'h1);
    tick();
    check("t1_dtack_e2", 32'(DtAck4), 32'h1);
    tick();
    check("t1_dtack_e3", 32'(DtAck4), 32'h0);
    check("t1_en_e3",    32'(En4),    32'h2);
    check("t1_berr_e3",  32'(BErr4),  32'h1);
    tick();
    check("t1_dtack_hold", 32'(DtAck4), 32'h0);
    AS_L = 1'b1;
    tick();
    check("t1_en_rel",    32'(En4),    32'h0);
    check("t1_dtack_rel", 32'(DtAck4), 32'h1);

    // Misses: one past top, below base, IOSelect low
    Address = 32'h0040_8040;
    AS_L    = 1'b0;
    repeat (6) tick();
    check("miss_top_en",    32'(En4),    32'h0);
    check("miss_top_dtack", 32'(DtAck4), 32'h1);
    check("miss_top_berr",  32'(BErr4),  32'h1);
    AS_L = 1'b1;
    tick();
    Address = 32'h0040_7FF0;
    AS_L    = 1'b0;
    repeat (6) tick();
    check("miss_low_en", 32'(En4), 32'h0);
    AS_L = 1'b1;
    tick();
    Address    = 32'h0040_8010;
    IOSelect_H = 1'b0;
    AS_L       = 1'b0;
    repeat (6) tick();
    check("miss_iosel_en",    32'(En4),    32'h0);
    check("miss_iosel_dtack", 32'(DtAck4), 32'h1);
    AS_L       = 1'b1;
    IOSelect_H = 1'b1;
    tick();

    // Timeout on channel 3
    Address = 32'h0040_8030;
    Ready4  = 4'b0111;
    AS_L    = 1'b0;
    tick();
    check("to_en_e0", 32'(En4), 32'h8);
    for (int i = 1; i <= 254; i++) tick();
    check("to_berr_e254",  32'(BErr4),  32'h1);
    tick();
    check("to_berr_e255",  32'(BErr4),  32'h0);
    check("to_en_e255",    32'(En4),    32'h8);
    check("to_dtack_e255", 32'(DtAck4), 32'h1);
    tick();
    check("to_berr_hold", 32'(BErr4), 32'h0);
    AS_L = 1'b1;
    tick();
    check("to_berr_rel", 32'(BErr4), 32'h1);
    check("to_en_rel",   32'(En4),   32'h0);

    // Address moves during WAIT; only channel 0 is ready
    Address = 32'h0040_8000;
    Ready4  = 4'b0001;
    AS_L    = 1'b0;
    tick();
    check("lat_en_e0", 32'(En4), 32'h1);
    Address = 32'h0040_8020;
    tick();
    tick();
    check("lat_en_e2", 32'(En4), 32'h1);
    tick();
    check("lat_dtack_e3", 32'(DtAck4), 32'h0);
    check("lat_en_e3",    32'(En4),    32'h1);
    AS_L = 1'b1;
    tick();

    // Abort mid-WAIT
    Address = 32'h0040_8010;
    Ready4  = 4'hF;
    AS_L    = 1'b0;
    tick();
    tick();
    AS_L = 1'b1;
    tick();
    check("abort_en",    32'(En4),    32'h0);
    check("abort_dtack", 32'(DtAck4), 32'h1);
    tick();
    tick();
    check("abort_dtack_late", 32'(DtAck4), 32'h1);

    // Reset during ACK, then immediate re-accept
    AS_L = 1'b0;
    repeat (4) tick();
    check("rack_dtack_pre", 32'(DtAck4), 32'h0);
    Reset_L = 1'b0;
    tick();
    check("rack_en",    32'(En4),    32'h0);
    check("rack_dtack", 32'(DtAck4), 32'h1);
    check("rack_berr",  32'(BErr4),  32'h1);
    Reset_L = 1'b1;
    tick();
    check("rack_reaccept_en", 32'(En4), 32'h2);
    AS_L = 1'b1;
    tick();

    // Eight channels, zero wait states
    Address = 32'h0040_8070;
    AS_L    = 1'b0;
    tick();
    check("c8_en_e0",    32'(En8),    32'h80);
    check("c8_dtack_e0", 32'(DtAck8), 32'h1);
    tick();
    check("c8_dtack_e1", 32'(DtAck8), 32'h0);
    check("c8_berr_e1",  32'(BErr8),  32'h1);
    AS_L = 1'b1;
    tick();
    check("c8_en_rel", 32'(En8), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_peripheral_decoder.md
IO_PERIPHERAL_DECODER -- requirements
Module: io_peripheral_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of peripheral channels, legal 1..8.
REQ-002 SHALL have parameter BASE_ADDR, default 16'h8000, low-16-bit address of channel 0; aligned to 2^STRIDE.
REQ-003 SHALL have parameter STRIDE, default 4, log2 of bytes per channel window, legal 1..8.
REQ-004 SHALL have parameter WAIT_STATES, default 2, minimum cycles in WAIT before acknowledge, legal 0..15.
REQ-005 SHALL have parameter TIMEOUT, default 255, cycles in WAIT before bus error, legal 16..255.
REQ-006 SHALL have one clock and a synchronous, active-low reset: Clock  in  1  system clock, all state updates on its rising edge.
REQ-007 SHALL have Reset_L  in  1  synchronous active-low reset.
REQ-008 SHALL have Address  in  32  CPU address; only [15:0] decoded.
REQ-009 SHALL have IOSelect_H  in  1  high for CPU I/O space 0040_0000-0040_FFFF.
REQ-010 SHALL have AS_L  in  1  CPU address strobe, active low.
REQ-011 SHALL have Ready_H  in  NUM_CH  per-channel peripheral ready.
REQ-012 SHALL have Enable_H  out  NUM_CH  registered one-hot channel enable.
REQ-013 SHALL have DtAck_L  out  1  registered data acknowledge, active low.
REQ-014 SHALL have BErr_L  out  1  registered bus error, active low.

Function
REQ-015 SHALL define hit = !AS_L & IOSelect_H & (BASE_ADDR <= Address[15:0] < BASE_ADDR + NUM_CH*2^STRIDE), 16-bit unsigned compare.
REQ-016 SHALL compute channel index = (Address[15:0] - BASE_ADDR) >> STRIDE, valid only on hit.
REQ-017 SHALL implement FSM states IDLE, WAIT, ACK, ERR.
REQ-018 IDLE: on hit at edge n, SHALL latch the index, clear the wait counter, set the matching Enable_H bit and enter WAIT; otherwise remain in IDLE with all outputs inactive.
REQ-019 WAIT: the counter SHALL increment each edge, saturating at 255.
REQ-020 WAIT: when counter >= WAIT_STATES and Ready_H[latched index] = 1, SHALL enter ACK and drive DtAck_L = 0.
REQ-021 WAIT: when counter = TIMEOUT-1 and REQ-020 is not met, SHALL enter ERR and drive BErr_L = 0; on the same edge, acknowledge takes priority.
REQ-022 ACK/ERR: SHALL hold DtAck_L or BErr_L low, and the Enable_H bit high, while AS_L = 0.
REQ-023 In WAIT, ACK or ERR, AS_L = 1 sampled at an edge SHALL return the FSM to IDLE with all outputs inactive on that edge; this covers abort mid-WAIT.
REQ-024 Once latched, the channel index SHALL NOT change until the FSM returns to IDLE, whatever Address does.
REQ-025 A new cycle SHALL start only from IDLE, so at least one cycle with AS_L = 1 is required between accesses.
REQ-026 DtAck_L and BErr_L SHALL never be low simultaneously, and Enable_H SHALL have at most one bit set.
REQ-027 Latency: with Ready_H high, DtAck_L SHALL first be low at edge n+1+WAIT_STATES.

Reset
REQ-028 Reset_L = 0 sampled at an edge SHALL force IDLE, Enable_H = 0, DtAck_L = 1, BErr_L = 1 and counter = 0, including during an active cycle.
REQ-029 After Reset_L returns to 1, the FSM SHALL accept a hit on the first following edge.

Verification
REQ-030 Defaults, Address = 0040_8010, IOSelect_H = 1, AS_L low at edge 0, Ready_H = 4'b1111 -> Enable_H = 4'b0010 after edge 0, DtAck_L low after edge 3, and all outputs clear one edge after AS_L goes high.
REQ-031 Address = 0040_8040 (one past the top channel) or IOSelect_H = 0 -> Enable_H = 0, DtAck_L = 1 and BErr_L = 1 for the whole cycle.
REQ-032 Address = 0040_8030, Ready_H[3] held at 0 -> BErr_L low after edge 255 with Enable_H = 4'b1000, and DtAck_L stays 1.
REQ-033 Address changed from 0040_8000 to 0040_8020 during WAIT -> Enable_H stays 4'b0001 and DtAck_L is issued.
REQ-034 AS_L released after edge 1 (mid-WAIT) -> FSM returns to IDLE and no DtAck_L pulse occurs; Reset_L = 0 during ACK -> all outputs inactive after the next edge.
REQ-035 WAIT_STATES = 0, NUM_CH = 8, Address = 0040_8070 -> Enable_H = 8'h80 after edge 0 and DtAck_L low after edge 1.
